osd_dii_channel_switch: RTL and testbench
=========================================

# osd_dii_channel_switch

Parametrised ingress/egress packet switch between the debug ring interface and a module's internals. It generalises the single register-bypass split to one register path plus NUM_CHANNELS module channels. Ingress packets are classified on their header and routed (or dropped); egress sources are merged by a packet-locked round-robin arbiter. It sits between the ring router and the module's regaccess unit plus event/trace channels.

## Interface
- NUM_CHANNELS, 2: number of module channels (1..16).
- CH_SEL_W, $clog2(NUM_CHANNELS) (min 1): channel index width.
- clk  in  1  clock.
- rst  in  1  reset; one clock, asynchronous, active-high.
- debug_in  in  dii_flit  ingress from ring; debug_in_ready  out  1.
- debug_out  out  dii_flit  egress to ring; debug_out_ready  in  1.
- reg_out  out  dii_flit  to regaccess; reg_out_ready  in  1.
- reg_in  in  dii_flit  from regaccess; reg_in_ready  out  1.
- ch_out  out  dii_flit[NUM_CHANNELS]  to channels; ch_out_ready  in  NUM_CHANNELS.
- ch_in  in  dii_flit[NUM_CHANNELS]  from channels; ch_in_ready  out  NUM_CHANNELS.
- drop_count  out  16  saturating count of dropped ingress packets.

## Operation
- Header: flit0 = dest, flit1 = src, flit2 = flags; TYPE = flags[15:14], TYPE_SUB = flags[13:10].
- Ingress FSM states: HDR0, HDR1, DECIDE, FLUSH0, FLUSH1, PASS, DROP.
  - HDR0/HDR1: debug_in_ready=1; store flit0/flit1 into a 2-entry header buffer.
  - DECIDE: debug_in_ready=0; inspect valid flit2 without consuming it.
    - TYPE=REG(0): target reg.
    - TYPE=EVENT(2) with TYPE_SUB<NUM_CHANNELS: target ch[TYPE_SUB].
    - Any other TYPE/TYPE_SUB: go to DROP.
  - FLUSH0/FLUSH1: present buf0/buf1 on the target output. Advance on target ready.
  - PASS: debug_in wired to the target (valid/ready passthrough). On accepted last -> HDR0.
  - DROP: debug_in_ready=1; consume all flits including flit2. On accepted last -> HDR0.
  - Short packet (last in HDR0/HDR1): drop it, count it, -> HDR0.
- drop_count: +1 on each transition into DROP or each short packet; saturates at 0xFFFF.
- Non-target outputs: valid=0.
- Egress arbiter: sources are index 0 = reg_in and index 1+k = ch_in[k].
  - Unlocked: grant the first valid source at or after ptr (round-robin, wrapping); forward it combinationally in the same cycle.
  - Accepted non-last flit: lock to that source.
  - Accepted last flit: unlock and set ptr = grant+1 (mod NUM_CHANNELS+1).
  - Only the granted source sees ready = debug_out_ready; all others get 0.

## Timing
- Reset (asynchronous, immediate): FSM=HDR0, header buffer cleared, drop_count=0, ptr=0, arbiter unlocked. All *_out.valid=0.
- Outputs after reset: debug_in_ready=1 (HDR0). reg_in_ready/ch_in_ready=0 unless debug_out_ready=1 and that source is granted.
- Ingress latency: flit0 reaches the target 1 cycle after flit2 is first presented in DECIDE. Throughput afterwards is 1 flit/cycle.
- A flit on debug_in is accepted iff valid && debug_in_ready. Outputs hold stable while valid && !ready.
- Egress: zero added latency, zero bubble between back-to-back packets from different sources.
- Reset mid-packet discards partial ingress/egress state; the next flit is treated as flit0.
- Simultaneous valid on all sources: grant rotates strictly; no source starves.

## Structure
- Add to dii_package: DII_TYPE_REG=2'd0, DII_TYPE_PLAIN=2'd1, DII_TYPE_EVENT=2'd2, and field positions DII_TYPE_MSB/LSB and DII_TYPE_SUB_MSB/LSB.
- One sub-module: osd_dii_packet_arbiter (parametrised N-input packet-locked round-robin mux). The ingress FSM stays in the top level.

## Test plan
- REG packet 0x0005,0x0001,0x0000,0xABCD(last) -> identical 4 flits on reg_out; ch_out silent; drop_count=0.
- EVENT, TYPE_SUB=1, NUM_CHANNELS=2, 6 flits, ch_out_ready[1] toggling -> all 6 on ch_out[1] in order, none lost or duplicated.
- EVENT, TYPE_SUB=5, then TYPE=PLAIN, then 2-flit short packet -> all consumed, nothing emitted, drop_count=3; 0xFFFF stays 0xFFFF.
- reg_in and ch_in[0..1] all hold 3-flit packets simultaneously -> debug_out sees source order 0,1,2,0; no interleaving within a packet.
- rst asserted mid-PASS and mid-locked-egress -> outputs invalid immediately; a fresh REG packet routes correctly afterwards.

Source files
------------

// File: rtl/osd_dii_channel_switch_pkg.sv
// rtl/osd_dii_channel_switch_pkg.sv - DII flit type, header field positions and ingress states
package osd_dii_channel_switch_pkg;

   typedef struct packed {
      logic        valid;
      logic        last;
      logic [15:0] data;
   } dii_flit;

   localparam logic [1:0] DII_TYPE_REG   = 2'd0;
   localparam logic [1:0] DII_TYPE_PLAIN = 2'd1;
   localparam logic [1:0] DII_TYPE_EVENT = 2'd2;

   localparam int DII_TYPE_MSB     = 15;
   localparam int DII_TYPE_LSB     = 14;
   localparam int DII_TYPE_SUB_MSB = 13;
   localparam int DII_TYPE_SUB_LSB = 10;

   typedef enum logic [2:0] {
      ST_HDR0,
      ST_HDR1,
      ST_DECIDE,
      ST_FLUSH0,
      ST_FLUSH1,
      ST_PASS,
      ST_DROP
   } ingress_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/osd_dii_channel_switch_arbiter.sv
// rtl/osd_dii_channel_switch_arbiter.sv - N-input packet-locked round-robin flit mux
module osd_dii_packet_arbiter
   import osd_dii_channel_switch_pkg::*;
#(
   parameter int N     = 2,
   parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  dii_flit [N-1:0]    in_flit,
   output logic    [N-1:0]    in_ready,
   output dii_flit            out_flit,
   input  logic               out_ready
);

   typedef logic [SEL_W:0] wide_t;

   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [SEL_W-1:0] grant_q, grant_d;
   logic             locked_q, locked_d;
   logic [SEL_W-1:0] pick;
   logic [SEL_W-1:0] grant;
   logic             found;
   logic             active;
   wide_t            cand;

   // First valid source at or after ptr, wrapping around.
   always_comb begin
      found = 1'b0;
      pick  = ptr_q;
      cand  = '0;
      for (int i = 0; i < N; i++) begin
         cand = wide_t'(ptr_q) + wide_t'(i);
         if (cand >= wide_t'(N)) cand = cand - wide_t'(N);
         if (!found && in_flit[cand[SEL_W-1:0]].valid) begin
            found = 1'b1;
            pick  = cand[SEL_W-1:0];
         end
      end
   end

   assign grant  = locked_q ? grant_q : pick;
   assign active = (locked_q || found) && !rst;

   always_comb begin
      out_flit       = in_flit[grant];
      out_flit.valid = in_flit[grant].valid & active;
      in_ready       = '0;
      if (active) in_ready[grant] = out_ready;
   end

   always_comb begin
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      locked_d = locked_q;
      if (out_flit.valid && out_ready) begin
         if (out_flit.last) begin
            locked_d = 1'b0;
            ptr_d    = (grant == SEL_W'(N - 1)) ? '0 : grant + SEL_W'(1);
         end else begin
            locked_d = 1'b1;
            grant_d  = grant;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q    <= '0;
         grant_q  <= '0;
         locked_q <= 1'b0;
      end else begin
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         locked_q <= locked_d;
      end
   end

endmodule

// File: rtl/osd_dii_channel_switch.sv
// rtl/osd_dii_channel_switch.sv - ingress classifier/router and egress merge between ring and module
module osd_dii_channel_switch
   import osd_dii_channel_switch_pkg::*;
#(
   parameter int NUM_CHANNELS = 2,
   parameter int CH_SEL_W     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  dii_flit                    debug_in,
   output logic                       debug_in_ready,
   output dii_flit                    debug_out,
   input  logic                       debug_out_ready,
   output dii_flit                    reg_out,
   input  logic                       reg_out_ready,
   input  dii_flit                    reg_in,
   output logic                       reg_in_ready,
   output dii_flit [NUM_CHANNELS-1:0] ch_out,
   input  logic    [NUM_CHANNELS-1:0] ch_out_ready,
   input  dii_flit [NUM_CHANNELS-1:0] ch_in,
   output logic    [NUM_CHANNELS-1:0] ch_in_ready,
   output logic    [15:0]             drop_count
);

   ingress_state_e        state_q, state_d;
   logic [1:0][15:0]      hdr_q, hdr_d;
   logic                  tgt_reg_q, tgt_reg_d;
   logic [CH_SEL_W-1:0]   tgt_ch_q, tgt_ch_d;
   logic [15:0]           drop_q, drop_d;

   logic [1:0]            flit_type;
   logic [3:0]            flit_sub;
   logic                  sub_ok;
   logic                  tgt_ready;
   dii_flit               fwd;

   assign flit_type = debug_in.data[DII_TYPE_MSB:DII_TYPE_LSB];
   assign flit_sub  = debug_in.data[DII_TYPE_SUB_MSB:DII_TYPE_SUB_LSB];
   assign sub_ok    = {1'b0, flit_sub} < 5'(NUM_CHANNELS);
   assign tgt_ready = tgt_reg_q ? reg_out_ready : ch_out_ready[tgt_ch_q];
   assign drop_count = drop_q;

   // flit2 is only peeked in DECIDE; it is consumed later by PASS or DROP.
   always_comb begin
      state_d        = state_q;
      hdr_d          = hdr_q;
      tgt_reg_d      = tgt_reg_q;
      tgt_ch_d       = tgt_ch_q;
      drop_d         = drop_q;
      debug_in_ready = 1'b0;
      fwd            = '0;
      unique case (state_q)
         ST_HDR0: begin
            debug_in_ready = 1'b1;
            if (debug_in.valid) begin
               hdr_d[0] = debug_in.data;
               if (debug_in.last) drop_d = sat_inc16(drop_q);
               else               state_d = ST_HDR1;
            end
         end
         ST_HDR1: begin
            debug_in_ready = 1'b1;
            if (debug_in.valid) begin
               hdr_d[1] = debug_in.data;
               if (debug_in.last) begin
                  drop_d  = sat_inc16(drop_q);
                  state_d = ST_HDR0;
               end else begin
                  state_d = ST_DECIDE;
               end
            end
         end
         ST_DECIDE: begin
            if (debug_in.valid) begin
               case (flit_type)
                  DII_TYPE_REG: begin
                     tgt_reg_d = 1'b1;
                     state_d   = ST_FLUSH0;
                  end
                  DII_TYPE_EVENT: begin
                     if (sub_ok) begin
                        tgt_reg_d = 1'b0;
                        tgt_ch_d  = flit_sub[CH_SEL_W-1:0];
                        state_d   = ST_FLUSH0;
                     end else begin
                        drop_d  = sat_inc16(drop_q);
                        state_d = ST_DROP;
                     end
                  end
                  DII_TYPE_PLAIN: begin
                     drop_d  = sat_inc16(drop_q);
                     state_d = ST_DROP;
                  end
                  default: begin
                     drop_d  = sat_inc16(drop_q);
                     state_d = ST_DROP;
                  end
               endcase
            end
         end
         ST_FLUSH0: begin
            fwd = '{valid: 1'b1, last: 1'b0, data: hdr_q[0]};
            if (tgt_ready) state_d = ST_FLUSH1;
         end
         ST_FLUSH1: begin
            fwd = '{valid: 1'b1, last: 1'b0, data: hdr_q[1]};
            if (tgt_ready) state_d = ST_PASS;
         end
         ST_PASS: begin
            fwd            = debug_in;
            debug_in_ready = tgt_ready;
            if (debug_in.valid && tgt_ready && debug_in.last) state_d = ST_HDR0;
         end
         ST_DROP: begin
            debug_in_ready = 1'b1;
            if (debug_in.valid && debug_in.last) state_d = ST_HDR0;
         end
         default: state_d = ST_HDR0;
      endcase
   end

   always_comb begin
      reg_out = '0;
      ch_out  = '0;
      if (tgt_reg_q) reg_out          = fwd;
      else           ch_out[tgt_ch_q] = fwd;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_HDR0;
         hdr_q     <= '0;
         tgt_reg_q <= 1'b1;
         tgt_ch_q  <= '0;
         drop_q    <= '0;
      end else begin
         state_q   <= state_d;
         hdr_q     <= hdr_d;
         tgt_reg_q <= tgt_reg_d;
         tgt_ch_q  <= tgt_ch_d;
         drop_q    <= drop_d;
      end
   end

   // Arbiter source 0 is the register path, source 1+k is channel k.
   dii_flit [NUM_CHANNELS:0] arb_in;
   logic    [NUM_CHANNELS:0] arb_ready;

   assign arb_in       = {ch_in, reg_in};
   assign reg_in_ready = arb_ready[0];
   assign ch_in_ready  = arb_ready[NUM_CHANNELS:1];

   osd_dii_packet_arbiter #(
      .N (NUM_CHANNELS + 1)
   ) u_arbiter (
      .clk       (clk),
      .rst       (rst),
      .in_flit   (arb_in),
      .in_ready  (arb_ready),
      .out_flit  (debug_out),
      .out_ready (debug_out_ready)
   );

endmodule

// File: tb/tb_osd_dii_channel_switch.sv
// tb/tb_osd_dii_channel_switch.sv - self-checking bench for osd_dii_channel_switch
module tb_osd_dii_channel_switch;
   import osd_dii_channel_switch_pkg::*;

   localparam int NC = 2;

   logic              clk = 1'b0;
   logic              rst;
   dii_flit           debug_in, debug_out, reg_out, reg_in;
   logic              debug_in_ready, debug_out_ready, reg_out_ready, reg_in_ready;
   dii_flit [NC-1:0]  ch_out, ch_in;
   logic    [NC-1:0]  ch_out_ready, ch_in_ready;
   logic    [15:0]    drop_count;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   logic [16:0] exp_reg[$], exp_ch0[$], exp_ch1[$], exp_dbg[$];
   logic [15:0] pkt[$];
   int          order_q[$];
   int          dbg_cycles[$];
   int          model_drops = 0;
   int          model_ptr   = 0;
   int          ch1_acc     = 0;
   dii_flit     prev_f[3];
   logic        prev_hold[3];

   osd_dii_channel_switch #(.NUM_CHANNELS(NC)) dut (
      .clk             (clk),
      .rst             (rst),
      .debug_in        (debug_in),
      .debug_in_ready  (debug_in_ready),
      .debug_out       (debug_out),
      .debug_out_ready (debug_out_ready),
      .reg_out         (reg_out),
      .reg_out_ready   (reg_out_ready),
      .reg_in          (reg_in),
      .reg_in_ready    (reg_in_ready),
      .ch_out          (ch_out),
      .ch_out_ready    (ch_out_ready),
      .ch_in           (ch_in),
      .ch_in_ready     (ch_in_ready),
      .drop_count      (drop_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic void model_drop();
      model_drops = (model_drops >= 65535) ? 65535 : model_drops + 1;
   endfunction

   // Routing decision from the packet as a whole: length, TYPE and TYPE_SUB.
   function automatic void model_ingress();
      logic [1:0] ty;
      logic [3:0] sub;
      if (pkt.size() < 3) begin
         model_drop();
         return;
      end
      ty  = pkt[2][15:14];
      sub = pkt[2][13:10];
      for (int i = 0; i < pkt.size(); i++) begin
         if (ty == 2'd0)                     exp_reg.push_back({i == pkt.size() - 1, pkt[i]});
         else if (ty == 2'd2 && sub == 4'd0) exp_ch0.push_back({i == pkt.size() - 1, pkt[i]});
         else if (ty == 2'd2 && sub == 4'd1) exp_ch1.push_back({i == pkt.size() - 1, pkt[i]});
      end
      if (!(ty == 2'd0 || (ty == 2'd2 && int'(sub) < NC))) model_drop();
   endfunction

   // Packet-level round robin over sources that all have packets waiting.
   function automatic void model_egress(input int p0, input int p1, input int p2);
      int pend[3];
      int pj[3];
      int s;
      pend[0] = p0; pend[1] = p1; pend[2] = p2;
      pj = '{0, 0, 0};
      order_q.delete();
      while (pend[0] + pend[1] + pend[2] > 0) begin
         s = model_ptr;
         while (pend[s] == 0) s = (s + 1) % 3;
         order_q.push_back(s);
         for (int k = 0; k < 3; k++)
            exp_dbg.push_back({k == 2, 16'((s << 8) | (pj[s] << 4) | k)});
         pj[s]++;
         pend[s]--;
         model_ptr = (s + 1) % 3;
      end
   endfunction

   function automatic dii_flit ing_flit(input int i);
      if (i == 0) return reg_out;
      return ch_out[i-1];
   endfunction

   function automatic logic ing_stall(input int i);
      if (i == 0) return reg_out.valid && !reg_out_ready;
      return ch_out[i-1].valid && !ch_out_ready[i-1];
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) prev_hold[i] <= 1'b0;
      end else begin
         if (reg_out.valid && reg_out_ready) begin
            if (exp_reg.size() == 0) check("reg_out_extra", 1, 0);
            else check("reg_out_flit", {15'd0, reg_out.last, reg_out.data}, {15'd0, exp_reg.pop_front()});
         end
         if (ch_out[0].valid && ch_out_ready[0]) begin
            if (exp_ch0.size() == 0) check("ch0_out_extra", 1, 0);
            else check("ch0_out_flit", {15'd0, ch_out[0].last, ch_out[0].data}, {15'd0, exp_ch0.pop_front()});
         end
         if (ch_out[1].valid && ch_out_ready[1]) begin
            ch1_acc <= ch1_acc + 1;
            if (exp_ch1.size() == 0) check("ch1_out_extra", 1, 0);
            else check("ch1_out_flit", {15'd0, ch_out[1].last, ch_out[1].data}, {15'd0, exp_ch1.pop_front()});
         end
         if (debug_out.valid && debug_out_ready) begin
            dbg_cycles.push_back(cycle);
            if (exp_dbg.size() == 0) check("debug_out_extra", 1, 0);
            else check("debug_out_flit", {15'd0, debug_out.last, debug_out.data}, {15'd0, exp_dbg.pop_front()});
         end
         for (int i = 0; i < 3; i++) begin
            if (prev_hold[i]) check("ingress_hold", 32'(ing_flit(i)), 32'(prev_f[i]));
            prev_hold[i] <= ing_stall(i);
            prev_f[i]    <= ing_flit(i);
         end
      end
   end

   // Drives pkt on debug_in; after lim accepted flits the next flit stays presented.
   task automatic send_pkt(input int lim);
      int n = 0;
      int budget;
      for (int i = 0; i < pkt.size(); i++) begin
         debug_in = '{valid: 1'b1, last: (i == pkt.size() - 1), data: pkt[i]};
         if (n == lim) return;
         budget = 0;
         forever begin
            @(negedge clk);
            if (debug_in_ready) break;
            budget++;
            if (budget > 500) begin
               check("ingress_timeout", 1, 0);
               debug_in = '0;
               return;
            end
         end
         @(posedge clk); #1;
         n++;
      end
      debug_in = '0;
   endtask

   task automatic set_src(input int s, input dii_flit f);
      if (s == 0) reg_in = f;
      else        ch_in[s-1] = f;
   endtask

   function automatic logic src_rdy(input int s);
      if (s == 0) return reg_in_ready;
      return ch_in_ready[s-1];
   endfunction

   task automatic src_send(input int s, input int n, input logic [15:0] base, input int lim);
      int budget;
      for (int k = 0; k < n; k++) begin
         set_src(s, '{valid: 1'b1, last: (k == n - 1), data: base + 16'(k)});
         if (k == lim) return;
         budget = 0;
         forever begin
            @(negedge clk);
            if (src_rdy(s)) break;
            budget++;
            if (budget > 500) begin
               check("egress_timeout", 1, 0);
               set_src(s, '0);
               return;
            end
         end
         @(posedge clk); #1;
      end
      set_src(s, '0);
   endtask

   task automatic drain_and_check_empty();
      repeat (6) @(posedge clk);
      #1;
      check("reg_q_left", 32'(exp_reg.size()), 0);
      check("ch0_q_left", 32'(exp_ch0.size()), 0);
      check("ch1_q_left", 32'(exp_ch1.size()), 0);
      check("dbg_q_left", 32'(exp_dbg.size()), 0);
      check("drop_count_model", {16'd0, drop_count}, 32'(model_drops));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      debug_in = '0; reg_in = '0; ch_in = '0;
      debug_out_ready = 1'b0; reg_out_ready = 1'b1; ch_out_ready = '1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_debug_in_ready", {31'd0, debug_in_ready}, 1);
      check("rst_reg_out_valid", {31'd0, reg_out.valid}, 0);
      check("rst_ch_out_valid", {30'd0, ch_out[1].valid, ch_out[0].valid}, 0);
      check("rst_debug_out_valid", {31'd0, debug_out.valid}, 0);
      check("rst_drop_count", {16'd0, drop_count}, 0);
      rst = 1'b0;
      debug_out_ready = 1'b1;
      @(posedge clk); #1;
      check("idle_reg_in_ready", {31'd0, reg_in_ready}, 0);
      check("idle_ch_in_ready", {30'd0, ch_in_ready}, 0);

      pkt = '{16'h0005, 16'h0001, 16'h0000, 16'hABCD};
      model_ingress();
      send_pkt(99);
      drain_and_check_empty();
      check("reg_pkt_drop_count", {16'd0, drop_count}, 0);

      pkt = '{16'h0005, 16'h0001, 16'h8400, 16'h1111, 16'h2222, 16'h3333};
      model_ingress();
      ch_out_ready[1] = 1'b0;
      fork
         send_pkt(99);
         repeat (40) begin
            @(posedge clk); #1;
            ch_out_ready[1] = ~ch_out_ready[1];
         end
      join
      ch_out_ready[1] = 1'b1;
      drain_and_check_empty();
      check("ch1_flit_count", 32'(ch1_acc), 6);

      pkt = '{16'h0005, 16'h0001, 16'h9400, 16'h0BAD};
      model_ingress();
      send_pkt(99);
      pkt = '{16'h0005, 16'h0001, 16'h4000, 16'h0BAD};
      model_ingress();
      send_pkt(99);
      pkt = '{16'h0005, 16'h0001};
      model_ingress();
      send_pkt(99);
      drain_and_check_empty();
      check("drops_three", {16'd0, drop_count}, 3);

      model_egress(2, 1, 1);
      check("rr_order_len", 32'(order_q.size()), 4);
      check("rr_order", 32'((order_q[0] << 12) | (order_q[1] << 8) | (order_q[2] << 4) | order_q[3]), 32'h0120);
      dbg_cycles.delete();
      fork
         begin
            src_send(0, 3, 16'h0000, 99);
            src_send(0, 3, 16'h0010, 99);
         end
         src_send(1, 3, 16'h0100, 99);
         src_send(2, 3, 16'h0200, 99);
      join
      drain_and_check_empty();
      check("rr_flits", 32'(dbg_cycles.size()), 12);
      if (dbg_cycles.size() == 12) check("rr_no_bubble", 32'(dbg_cycles[11] - dbg_cycles[0]), 11);

      pkt = '{16'h0005, 16'h0001, 16'h0000, 16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0014};
      model_ingress();
      for (int k = 0; k < 5; k++) exp_dbg.push_back({k == 4, 16'h0900 + 16'(k)});
      send_pkt(5);
      reg_out_ready = 1'b0;
      src_send(1, 5, 16'h0900, 2);
      debug_out_ready = 1'b0;
      #1;
      check("pre_rst_reg_out_valid", {31'd0, reg_out.valid}, 1);
      check("pre_rst_debug_out_valid", {31'd0, debug_out.valid}, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_reg_out_valid", {31'd0, reg_out.valid}, 0);
      check("mid_rst_debug_out_valid", {31'd0, debug_out.valid}, 0);
      check("mid_rst_ch_in_ready", {30'd0, ch_in_ready}, 0);
      check("mid_rst_debug_in_ready", {31'd0, debug_in_ready}, 1);
      debug_in = '0; reg_in = '0; ch_in = '0;
      reg_out_ready = 1'b1; debug_out_ready = 1'b1;
      exp_reg.delete(); exp_ch0.delete(); exp_ch1.delete(); exp_dbg.delete();
      model_drops = 0;
      model_ptr   = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      check("post_rst_drop_count", {16'd0, drop_count}, 0);

      pkt = '{16'h0005, 16'h0001, 16'h0000, 16'h7777, 16'h8888};
      model_ingress();
      send_pkt(99);
      drain_and_check_empty();

      model_egress(1, 1, 0);
      check("post_rst_rr_first", 32'(order_q[0]), 0);
      fork
         src_send(0, 3, 16'h0000, 99);
         src_send(1, 3, 16'h0100, 99);
      join
      drain_and_check_empty();

      debug_in = '{valid: 1'b1, last: 1'b1, data: 16'h0000};
      repeat (65540) @(posedge clk);
      #1;
      debug_in = '0;
      for (int i = 0; i < 65540; i++) model_drop();
      drain_and_check_empty();
      check("drop_count_saturated", {16'd0, drop_count}, 32'h0000FFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
